// File: rtl/bus_arbiter_if.sv
// Request/grant signal bundle shared by the CPU-bus arbiter and its requesters.
// The arbiter uses the master modport. Requesters, or a bench acting for them, use the slave modport.
interface bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] i_lock;
    logic [N_REQ-1:0] o_grant;
    logic [IDW-1:0]   o_grantId;
    logic             o_busy;
    logic             o_timeout;

    modport master (
        input  i_req,
        input  i_lock,
        output o_grant,
        output o_grantId,
        output o_busy,
        output o_timeout
    );

    modport slave (
        output i_req,
        output i_lock,
        input  o_grant,
        input  o_grantId,
        input  o_busy,
        input  o_timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 24-bit CPU bus. It enforces a hold-time limit and
// inserts an idle turnaround window after every ownership change.
module bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bus_arbiter_if.master bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam int TW  = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [IDW-1:0]   LAST_INIT = IDW'(N_REQ - 1);
    localparam logic [HW-1:0]    HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0]    HOLD_LIM  = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0]    TURN_INIT = TW'(TURNAROUND - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  last_r;
    logic [HW-1:0]   hold_r;
    logic [TW-1:0]   turn_r;

    logic [IDW:0]    pick_s;
    logic            found_s;
    logic [IDW-1:0]  winner_s;
    logic            others_s;
    logic            rel_norm_s;
    logic            rel_pre_s;

    // The search starts just after the last owner, so the previous owner has the lowest priority.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDW-1:0] last);
        logic           found;
        logic [IDW-1:0] win;
        logic [IDW-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDW'((int'(last) + i) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // Select the next winner and evaluate the owner's release conditions.
    always_comb begin
        pick_s     = rr_pick(bus.i_req, last_r);
        found_s    = pick_s[IDW];
        winner_s   = pick_s[IDW-1:0];
        others_s   = |(bus.i_req & ~bus.o_grant);
        rel_norm_s = ~bus.i_req[last_r];
        rel_pre_s  = (hold_r >= HOLD_LIM) & ~bus.i_lock[last_r] & others_s;
    end

    // Arbitration FSM. All outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r       <= IDLE;
            last_r        <= LAST_INIT;
            hold_r        <= '0;
            turn_r        <= '0;
            bus.o_grant   <= '0;
            bus.o_grantId <= '0;
            bus.o_busy    <= 1'b0;
            bus.o_timeout <= 1'b0;
        end else begin
            bus.o_timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r       <= GRANT;
                        bus.o_grant   <= ONE_HOT0 << winner_s;
                        bus.o_grantId <= winner_s;
                        bus.o_busy    <= 1'b1;
                        last_r        <= winner_s;
                        hold_r        <= '0;
                    end
                end
                GRANT: begin
                    if (rel_norm_s || rel_pre_s) begin
                        state_r       <= TURN;
                        bus.o_grant   <= '0;
                        bus.o_busy    <= 1'b0;
                        bus.o_timeout <= ~rel_norm_s;
                        turn_r        <= TURN_INIT;
                    end else if (hold_r < HOLD_MAX) begin
                        hold_r <= hold_r + HW'(1);
                    end
                end
                TURN: begin
                    // When the count reaches zero, arbitrate again in this same cycle. This adds no extra gap cycle.
                    if (turn_r != '0) begin
                        turn_r <= turn_r - TW'(1);
                    end else if (found_s) begin
                        state_r       <= GRANT;
                        bus.o_grant   <= ONE_HOT0 << winner_s;
                        bus.o_grantId <= winner_s;
                        bus.o_busy    <= 1'b1;
                        last_r        <= winner_s;
                        hold_r        <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    bus.o_grant <= '0;
                    bus.o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. Per-cycle expectations are queued when inputs are driven.
// They are popped and compared after each clock edge.
module tb_bus_arbiter;
    logic clk;
    logic rst0;
    logic rst3;

    bus_arbiter_if #(.N_REQ(4)) bus0 ();
    bus_arbiter_if #(.N_REQ(4)) bus3 ();

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURNAROUND(1)) dut (
        .i_clk   (clk),
        .i_reset (rst0),
        .bus     (bus0)
    );

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURNAROUND(3)) dut3 (
        .i_clk   (clk),
        .i_reset (rst3),
        .bus     (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        int         ncyc;
        logic [3:0] grant;
        logic [1:0] id;
        logic       tmo;
    } vec_t;

    typedef struct {
        logic       sel;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic vec_t mk(input logic sel, input logic rst, input logic [3:0] req,
                                input logic [3:0] lock, input int n, input logic [3:0] g,
                                input logic [1:0] id, input logic t);
        vec_t v;
        v.sel = sel; v.rst = rst; v.req = req; v.lock = lock; v.ncyc = n;
        v.grant = g; v.id = id; v.tmo = t;
        return v;
    endfunction

    task automatic compare(input string name, input int vi, input int c, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s vec %0d cycle %0d: got %0d expected %0d", name, vi, c, act, want);
        end
    endtask

    task automatic check_out(input int vi, input int c);
        exp_t       e;
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard vec %0d cycle %0d: no expected entry", vi, c);
        end else begin
            e  = exp_q.pop_front();
            g  = e.sel ? bus3.o_grant   : bus0.o_grant;
            id = e.sel ? bus3.o_grantId : bus0.o_grantId;
            b  = e.sel ? bus3.o_busy    : bus0.o_busy;
            t  = e.sel ? bus3.o_timeout : bus0.o_timeout;
            compare("grant",   vi, c, int'(g),  int'(e.grant));
            compare("grantId", vi, c, int'(id), int'(e.id));
            compare("busy",    vi, c, int'(b),  int'(e.busy));
            compare("timeout", vi, c, int'(t),  int'(e.tmo));
        end
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        exp_t e;
        for (int c = 0; c < v.ncyc; c++) begin
            @(negedge clk);
            if (v.sel) begin
                rst3 = v.rst; bus3.i_req = v.req; bus3.i_lock = v.lock;
                rst0 = 1'b1;  bus0.i_req = 4'b0000; bus0.i_lock = 4'b0000;
            end else begin
                rst0 = v.rst; bus0.i_req = v.req; bus0.i_lock = v.lock;
                rst3 = 1'b1;  bus3.i_req = 4'b0000; bus3.i_lock = 4'b0000;
            end
            e.sel = v.sel; e.grant = v.grant; e.id = v.id; e.busy = |v.grant; e.tmo = v.tmo;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            check_out(vi, c);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst0 = 1'b1; rst3 = 1'b1;
        bus0.i_req = 4'b0000; bus0.i_lock = 4'b0000;
        bus3.i_req = 4'b0000; bus3.i_lock = 4'b0000;

        // Round robin with all four requesting. Each grant lasts 16 cycles and ends in a timeout.
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000,  2, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 16, 4'b0001, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000,  1, 4'b0000, 2'd0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 16, 4'b0010, 2'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000,  1, 4'b0000, 2'd1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 16, 4'b0100, 2'd2, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000,  1, 4'b0000, 2'd2, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 16, 4'b1000, 2'd3, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000,  1, 4'b0000, 2'd3, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000,  2, 4'b0001, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0000,  3, 4'b0000, 2'd0, 1'b0));
        // A lone requester keeps the grant past the hold limit.
        vecs.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0000, 40, 4'b0100, 2'd2, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0000,  3, 4'b0000, 2'd2, 1'b0));
        // A locked owner ignores the hold limit. When it releases normally, there is no timeout.
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000,  1, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0010, 4'b0010,  1, 4'b0010, 2'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 4'b0010, 20, 4'b0010, 2'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 4'b0010,  1, 4'b0000, 2'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 4'b0010,  3, 4'b0001, 2'd0, 1'b0));
        // Reset during a grant drops it immediately. Afterwards requester 0 has top priority.
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000,  1, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1000, 4'b0000,  2, 4'b1000, 2'd3, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b1001, 4'b0000,  1, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 4'b0000, 16, 4'b0001, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 4'b0000,  1, 4'b0000, 2'd0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 4'b0000,  1, 4'b1000, 2'd3, 1'b0));
        // Wrap-around from last=3 with requests 1010.
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000,  1, 4'b0000, 2'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1010, 4'b0000, 16, 4'b0010, 2'd1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1010, 4'b0000,  1, 4'b0000, 2'd1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1010, 4'b0000,  2, 4'b1000, 2'd3, 1'b0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // With TURNAROUND=3, there are exactly three idle cycles between owners.
        run_vec(mk(1'b1, 1'b1, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 1'b0), 100);
        run_vec(mk(1'b1, 1'b0, 4'b0001, 4'b0000, 2, 4'b0001, 2'd0, 1'b0), 101);
        run_vec(mk(1'b1, 1'b0, 4'b0100, 4'b0000, 3, 4'b0000, 2'd0, 1'b0), 102);
        run_vec(mk(1'b1, 1'b0, 4'b0100, 4'b0000, 2, 4'b0100, 2'd2, 1'b0), 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
